card_read_buffer: RTL and testbench
===================================

# card_read_buffer

Card-image buffer sitting directly downstream of the hole-to-EBCDIC column translator in the 2821 card-reader path. It captures one card's worth of translated columns (EBCDIC byte plus per-column invalid-punch flag) as they arrive from the read station. It then streams the bytes in column order to the channel side over a valid/ready handshake. It records the validity-check status for the card: a sticky error flag plus the index of the first bad column.

## Interface
Parameters:
- COLS, 80, columns per card; legal range 1..127.

Ports:
- i_clk  in  1  clock; all logic on rising edge.
- i_reset  in  1  reset, synchronous, active-low.
- i_card_start  in  1  one-cycle pulse: a new card begins; honoured only in IDLE.
- i_col_valid  in  1  one translated column presented this cycle.
- i_col_ebcdic  in  8  translator EBCDIC output for the column.
- i_col_bad  in  1  translator invalid-punch flag for the column.
- o_byte  out  8  buffered EBCDIC byte toward the channel.
- o_byte_valid  out  1  o_byte is valid.
- i_byte_ready  in  1  consumer accepts o_byte this cycle.
- o_card_done  out  1  one-cycle pulse: the last byte of the card was accepted.
- o_busy  out  1  high in FILL or DRAIN.
- o_valid_check  out  1  sticky: at least one bad column was seen since the last clear.
- o_bad_col  out  7  column index (0-based) of the first bad column since the last clear.
- o_overrun  out  1  sticky: a column arrived outside FILL.
- i_clear  in  1  clears o_valid_check, o_bad_col and o_overrun.

## Operation
- States: IDLE, FILL, DRAIN.
- IDLE
  - i_card_start moves to FILL; write pointer set to 0.
  - i_col_valid in IDLE is discarded and sets o_overrun.
- FILL
  - Each i_col_valid writes i_col_ebcdic to buffer[wr_ptr] and increments wr_ptr.
  - After the write of column COLS-1, the state moves to DRAIN.
  - Gaps between columns of any length are legal.
- Bad-column capture
  - On a FILL write with i_col_bad=1: o_valid_check is set.
  - If o_valid_check was previously 0, o_bad_col is loaded with wr_ptr. Later bad columns leave o_bad_col unchanged.
- DRAIN
  - Bytes are presented in order, column 0 to COLS-1.
  - A transfer occurs when o_byte_valid and i_byte_ready are both high. rd_ptr advances on each transfer.
  - On the transfer of column COLS-1: o_card_done pulses, o_byte_valid drops, and the state moves to IDLE.
  - i_col_valid in DRAIN is discarded, sets o_overrun, and does not alter buffer contents.
- i_card_start outside IDLE is ignored, including the cycle of the final DRAIN transfer.
- i_clear
  - Clears the sticky flags and o_bad_col.
  - If a set condition occurs in the same cycle, the set wins: the flag ends at 1, and o_bad_col takes the new index.
- Pointers are 7 bits. They never wrap mid-card: FILL ends at COLS-1, and DRAIN ends at COLS-1.

## Timing
- Reset values (cycle after i_reset low at an edge):
  - State IDLE; pointers 0.
  - o_byte=0x00, o_byte_valid=0, o_card_done=0, o_busy=0.
  - o_valid_check=0, o_bad_col=0, o_overrun=0.
  - Buffer contents are don't-care.
- Reset mid-FILL or mid-DRAIN abandons the card: no o_card_done pulse, and the partial card is never presented.
- o_busy rises the cycle after an accepted i_card_start and falls the cycle after the final transfer, coincident with o_card_done.
- Latency from the last column's write edge to o_byte_valid=1 with o_byte=column 0: one cycle.
- Throughput is one byte per cycle while i_byte_ready is held high. All outputs are registered.
- While o_byte_valid=1 and i_byte_ready=0, o_byte holds stable.
- o_byte_valid is never dropped before the corresponding transfer.
- o_byte after the final transfer holds its last value and is don't-care.

## Structure
- Shared package x2821_pkg:
  - state enumeration (IDLE/FILL/DRAIN);
  - default column count CARD_COLS=80;
  - column-index width COL_W=7.
- Sub-module card_col_ram: COLS×8 storage with one synchronous write port and one read port. The read port is addressed by the next rd_ptr so the output register reloads in the same cycle as a transfer.
- FSM, pointers, sticky flags and the output register live in card_read_buffer.

## Test plan
- Normal card: start, 80 columns with ebcdic=index, i_byte_ready=1 -> 80 transfers of bytes 0x00..0x4F back-to-back. o_card_done pulses on the transfer of 0x4F. o_valid_check=0, o_overrun=0.
- Bad columns: i_col_bad on columns 37 and 50 -> o_valid_check=1, o_bad_col=37. All 80 bytes still drain intact.
- Backpressure: i_byte_ready pattern 1,0,0,1,0,1 repeating -> exactly 80 transfers with no loss or duplicate. o_byte is stable during every valid-and-not-ready cycle.
- Overrun: one i_col_valid in IDLE and one in DRAIN -> o_overrun=1, and the drained data equals the original card. i_clear then returns o_overrun to 0.
- Reset mid-fill after 40 columns -> all outputs at reset values on the next cycle. A following full card drains correctly with o_bad_col=0.
- Clear/set collision: i_clear in the same cycle as a bad column 5 on a clean card -> o_valid_check=1, o_bad_col=5.

Source files
------------

// File: rtl/x2821_pkg.sv
// Shared definitions for the 2821 card-reader read path.
package x2821_pkg;
  localparam int CARD_COLS = 80;
  localparam int COL_W     = 7;

  typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;
endpackage

// File: rtl/card_col_ram.sv
// Column store for one card: synchronous write, combinational read.
module card_col_ram
  import x2821_pkg::*;
#(
  parameter int COLS = CARD_COLS
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [COL_W-1:0] i_waddr,
  input  logic [7:0]       i_wdata,
  input  logic [COL_W-1:0] i_raddr,
  output logic [7:0]       o_rdata
);
  logic [7:0] r_mem [COLS];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/card_read_buffer.sv
// Captures one card of translated columns, then streams it to the channel
// over valid/ready while tracking invalid-punch and overrun status.
module card_read_buffer
  import x2821_pkg::*;
#(
  parameter int COLS = CARD_COLS
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_card_start,
  input  logic             i_col_valid,
  input  logic [7:0]       i_col_ebcdic,
  input  logic             i_col_bad,
  output logic [7:0]       o_byte,
  output logic             o_byte_valid,
  input  logic             i_byte_ready,
  output logic             o_card_done,
  output logic             o_busy,
  output logic             o_valid_check,
  output logic [COL_W-1:0] o_bad_col,
  output logic             o_overrun,
  input  logic             i_clear
);
  localparam logic [COL_W-1:0] LAST = COL_W'(COLS - 1);

  state_t           r_state, w_state_nxt;
  logic [COL_W-1:0] r_wr_ptr, r_rd_ptr, w_rd_addr, r_bad_col;
  logic [7:0]       w_rd_data, r_byte;
  logic             r_byte_valid, r_card_done, r_busy, r_valid_check, r_overrun;
  logic             w_wr, w_bad_wr, w_xfer, w_last_xfer;

  assign w_wr        = (r_state == FILL) && i_col_valid;
  assign w_bad_wr    = w_wr && i_col_bad;
  assign w_xfer      = r_byte_valid && i_byte_ready;
  assign w_last_xfer = w_xfer && (r_rd_ptr == LAST);
  // Look one column ahead on a transfer so the output register refills without a bubble.
  assign w_rd_addr   = (w_xfer && !w_last_xfer) ? r_rd_ptr + COL_W'(1) : r_rd_ptr;

  card_col_ram #(.COLS(COLS)) u_ram (
    .i_clk   (i_clk),
    .i_we    (w_wr),
    .i_waddr (r_wr_ptr),
    .i_wdata (i_col_ebcdic),
    .i_raddr (w_rd_addr),
    .o_rdata (w_rd_data)
  );

  always_ff @(posedge i_clk) begin
    if (!i_reset) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (i_card_start) w_state_nxt = FILL;
      FILL:    if (i_col_valid && r_wr_ptr == LAST) w_state_nxt = DRAIN;
      DRAIN:   if (w_last_xfer) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_byte        <= '0;
      r_byte_valid  <= 1'b0;
      r_card_done   <= 1'b0;
      r_busy        <= 1'b0;
      r_valid_check <= 1'b0;
      r_bad_col     <= '0;
      r_overrun     <= 1'b0;
    end else begin
      r_busy      <= (w_state_nxt != IDLE);
      r_card_done <= w_last_xfer;

      if (r_state == IDLE && i_card_start) r_wr_ptr <= '0;
      else if (w_wr) r_wr_ptr <= (r_wr_ptr == LAST) ? '0 : r_wr_ptr + COL_W'(1);

      // First DRAIN cycle primes the output register with column 0.
      if (r_state == DRAIN) begin
        if (!r_byte_valid) begin
          r_byte       <= w_rd_data;
          r_byte_valid <= 1'b1;
        end else if (w_last_xfer) begin
          r_byte_valid <= 1'b0;
          r_rd_ptr     <= '0;
        end else if (w_xfer) begin
          r_byte   <= w_rd_data;
          r_rd_ptr <= r_rd_ptr + COL_W'(1);
        end
      end

      // Set beats clear when both land in the same cycle.
      if (w_bad_wr) begin
        r_valid_check <= 1'b1;
        if (!r_valid_check || i_clear) r_bad_col <= r_wr_ptr;
      end else if (i_clear) begin
        r_valid_check <= 1'b0;
        r_bad_col     <= '0;
      end

      if (i_col_valid && r_state != FILL) r_overrun <= 1'b1;
      else if (i_clear)                   r_overrun <= 1'b0;
    end
  end

  assign o_byte        = r_byte;
  assign o_byte_valid  = r_byte_valid;
  assign o_card_done   = r_card_done;
  assign o_busy        = r_busy;
  assign o_valid_check = r_valid_check;
  assign o_bad_col     = r_bad_col;
  assign o_overrun     = r_overrun;
endmodule

// File: tb/tb_card_read_buffer.sv
// Directed bench for card_read_buffer: fill/drain, bad columns, backpressure,
// overrun, mid-fill reset and clear/set collision.
module tb_card_read_buffer;
  localparam int COLS = 80;

  logic       clk = 1'b0;
  logic       i_reset = 1'b0;
  logic       i_card_start = 1'b0;
  logic       i_col_valid = 1'b0;
  logic [7:0] i_col_ebcdic = '0;
  logic       i_col_bad = 1'b0;
  logic [7:0] o_byte;
  logic       o_byte_valid;
  logic       i_byte_ready = 1'b0;
  logic       o_card_done;
  logic       o_busy;
  logic       o_valid_check;
  logic [6:0] o_bad_col;
  logic       o_overrun;
  logic       i_clear = 1'b0;

  int         errors = 0;
  int         checks = 0;
  logic [7:0] exp_mem [COLS];
  logic [5:0] rdy_pat;

  card_read_buffer #(.COLS(COLS)) dut (
    .i_clk         (clk),
    .i_reset       (i_reset),
    .i_card_start  (i_card_start),
    .i_col_valid   (i_col_valid),
    .i_col_ebcdic  (i_col_ebcdic),
    .i_col_bad     (i_col_bad),
    .o_byte        (o_byte),
    .o_byte_valid  (o_byte_valid),
    .i_byte_ready  (i_byte_ready),
    .o_card_done   (o_card_done),
    .o_busy        (o_busy),
    .o_valid_check (o_valid_check),
    .o_bad_col     (o_bad_col),
    .o_overrun     (o_overrun),
    .i_clear       (i_clear)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_state();
    chk("rst_byte", o_byte, 0);
    chk("rst_valid", o_byte_valid, 0);
    chk("rst_done", o_card_done, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_vcheck", o_valid_check, 0);
    chk("rst_badcol", o_bad_col, 0);
    chk("rst_overrun", o_overrun, 0);
  endtask

  // Columns come from exp_mem; a 'gap' idle cycles follow every column with c%7==3.
  task automatic fill(input int bad1, input int bad2, input int gap, input int clr_at);
    i_card_start = 1'b1;
    tick();
    i_card_start = 1'b0;
    chk("busy_rise", o_busy, 1);
    for (int c = 0; c < COLS; c++) begin
      i_col_valid  = 1'b1;
      i_col_ebcdic = exp_mem[c];
      i_col_bad    = (c == bad1) || (c == bad2);
      i_clear      = (c == clr_at);
      tick();
      i_col_valid = 1'b0;
      i_col_bad   = 1'b0;
      i_clear     = 1'b0;
      if (gap > 0 && (c % 7) == 3) repeat (gap) tick();
    end
  endtask

  // mode 0: ready held high; mode 1: ready follows 1,0,0,1,0,1 repeating.
  task automatic drain(input int mode);
    int         n = 0;
    int         cyc = 0;
    int         ph = 0;
    logic       hold = 1'b0;
    logic [7:0] held = '0;
    logic       lastx;
    while (n < COLS && cyc < 4 * COLS + 20) begin
      i_byte_ready = (mode == 0) ? 1'b1 : rdy_pat[ph];
      ph = (ph == 5) ? 0 : ph + 1;
      if (hold) begin
        chk("hold_valid", o_byte_valid, 1);
        chk("hold_byte", o_byte, held);
      end
      hold  = 1'b0;
      lastx = 1'b0;
      if (o_byte_valid && i_byte_ready) begin
        chk("byte", o_byte, exp_mem[n]);
        n++;
        lastx = (n == COLS);
      end else if (o_byte_valid) begin
        hold = 1'b1;
        held = o_byte;
      end
      tick();
      chk("done", o_card_done, lastx);
      cyc++;
    end
    i_byte_ready = 1'b0;
    chk("xfer_count", n, COLS);
    chk("busy_fall", o_busy, 0);
    chk("valid_fall", o_byte_valid, 0);
  endtask

  initial begin
    rdy_pat = 6'b101001;

    // Reset
    i_reset = 1'b0;
    tick();
    tick();
    chk_reset_state();
    i_reset = 1'b1;
    tick();

    // Normal card, plus first-byte latency with ready low
    for (int c = 0; c < COLS; c++) exp_mem[c] = 8'(c);
    fill(-1, -1, 0, -1);
    tick();
    chk("lat_valid", o_byte_valid, 1);
    chk("lat_byte", o_byte, 8'h00);
    drain(0);
    chk("n_vcheck", o_valid_check, 0);
    chk("n_overrun", o_overrun, 0);

    // Bad columns 37 and 50, gapped fill, backpressured drain
    for (int c = 0; c < COLS; c++) exp_mem[c] = 8'(c) ^ 8'hA5;
    fill(37, 50, 2, -1);
    drain(1);
    chk("b_vcheck", o_valid_check, 1);
    chk("b_badcol", o_bad_col, 37);
    chk("b_overrun", o_overrun, 0);
    i_clear = 1'b1;
    tick();
    i_clear = 1'b0;
    chk("b_clr_vcheck", o_valid_check, 0);
    chk("b_clr_badcol", o_bad_col, 0);

    // Overrun in IDLE, then in DRAIN (with a stray start and bad flag)
    i_col_valid  = 1'b1;
    i_col_ebcdic = 8'hFF;
    tick();
    i_col_valid = 1'b0;
    chk("o_idle_overrun", o_overrun, 1);
    chk("o_idle_busy", o_busy, 0);
    i_clear = 1'b1;
    tick();
    i_clear = 1'b0;
    chk("o_clr1", o_overrun, 0);
    for (int c = 0; c < COLS; c++) exp_mem[c] = 8'(c * 3);
    fill(-1, -1, 0, -1);
    tick();
    i_col_valid  = 1'b1;
    i_col_ebcdic = 8'hEE;
    i_col_bad    = 1'b1;
    i_card_start = 1'b1;
    tick();
    i_col_valid  = 1'b0;
    i_col_bad    = 1'b0;
    i_card_start = 1'b0;
    chk("o_drain_overrun", o_overrun, 1);
    chk("o_drain_vcheck", o_valid_check, 0);
    chk("o_drain_busy", o_busy, 1);
    drain(0);
    tick();
    chk("o_idle_after", o_busy, 0);
    i_clear = 1'b1;
    tick();
    i_clear = 1'b0;
    chk("o_clr2", o_overrun, 0);

    // Reset after 40 columns, one of them bad
    for (int c = 0; c < COLS; c++) exp_mem[c] = 8'(255 - c);
    i_card_start = 1'b1;
    tick();
    i_card_start = 1'b0;
    for (int c = 0; c < 40; c++) begin
      i_col_valid  = 1'b1;
      i_col_ebcdic = exp_mem[c];
      i_col_bad    = (c == 10);
      tick();
    end
    i_col_valid = 1'b0;
    i_col_bad   = 1'b0;
    i_reset     = 1'b0;
    tick();
    i_reset = 1'b1;
    chk_reset_state();
    i_byte_ready = 1'b1;
    repeat (5) tick();
    chk("r_no_valid", o_byte_valid, 0);
    chk("r_no_busy", o_busy, 0);
    chk("r_no_done", o_card_done, 0);
    i_byte_ready = 1'b0;
    for (int c = 0; c < COLS; c++) exp_mem[c] = 8'(c) ^ 8'h3C;
    fill(-1, -1, 1, -1);
    drain(1);
    chk("r_vcheck", o_valid_check, 0);
    chk("r_badcol", o_bad_col, 0);

    // Clear coincident with bad column 5 on a clean card
    for (int c = 0; c < COLS; c++) exp_mem[c] = 8'(c + 1);
    fill(5, -1, 0, 5);
    chk("c_vcheck_fill", o_valid_check, 1);
    drain(0);
    chk("c_vcheck", o_valid_check, 1);
    chk("c_badcol", o_bad_col, 5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
